// File: rtl/pwd_pkg.sv
// rtl/pwd_pkg.sv - shared state encoding and default width bounds for the pulse width decoder
// Ports: none (package).
package pwd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_PAY  = 2'd2,
    ST_HOLD = 2'd3
  } pwd_state_t;

  // Pulse width classification bounds in clock cycles, inclusive.
  // The backscatter modulator uses the same values.
  localparam int LB0_DEFAULT = 400;
  localparam int UB0_DEFAULT = 600;
  localparam int LB1_DEFAULT = 1200;
  localparam int UB1_DEFAULT = 1600;

  localparam logic [3:0] HEADER_DEFAULT = 4'b1010;

endpackage

// File: rtl/pulse_width_meter.sv
// rtl/pulse_width_meter.sv - synchronises the trigger input and measures each high pulse width
// Ports:
//   clock, reset    : system clock, asynchronous active-high reset
//   trigger_signal  : raw envelope detector output (asynchronous)
//   trig_s          : synchronised trigger level
//   rise, fall      : single-cycle edge strobes on trig_s
//   width           : saturating high-time count, valid on the fall strobe
module pulse_width_meter #(
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             trigger_signal,
  output logic             trig_s,
  output logic             rise,
  output logic             fall,
  output logic [CNT_W-1:0] width
);

  logic sync_q;
  logic trig_d;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_q <= 1'b0;
      trig_s <= 1'b0;
      trig_d <= 1'b0;
    end else begin
      sync_q <= trigger_signal;
      trig_s <= sync_q;
      trig_d <= trig_s;
    end
  end

  assign rise = trig_s & ~trig_d;
  assign fall = ~trig_s & trig_d;

  // The rise cycle is itself a high cycle, so the counter restarts at 1;
  // on the fall strobe width equals the number of cycles trig_s was high.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      width <= '0;
    end else if (rise) begin
      width <= CNT_W'(1);
    end else if (trig_s && !(&width)) begin
      width <= width + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pulse_width_decoder.sv
// rtl/pulse_width_decoder.sv - decodes pulse-width-coded downlink frames and hands them downstream
// Ports:
//   clock, reset    : system clock, asynchronous active-high reset
//   trigger_signal  : envelope detector output (asynchronous)
//   frame_valid     : frame_data holds a complete header-matched frame
//   frame_ready     : downstream accepts the frame
//   frame_data      : payload, first received bit in the MSB
//   overrun         : one-cycle pulse per pulse completing while a frame is held
//   bit_error       : one-cycle pulse on bad width, gap timeout or header mismatch
module pulse_width_decoder
  import pwd_pkg::*;
#(
  parameter int                  CNT_W    = 16,
  parameter int                  LB0      = LB0_DEFAULT,
  parameter int                  UB0      = UB0_DEFAULT,
  parameter int                  LB1      = LB1_DEFAULT,
  parameter int                  UB1      = UB1_DEFAULT,
  parameter int                  HDR_BITS = 4,
  parameter logic [HDR_BITS-1:0] HEADER   = HDR_BITS'(HEADER_DEFAULT),
  parameter int                  PAY_BITS = 16,
  parameter int                  GAP_MAX  = 8000
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                trigger_signal,
  output logic                frame_valid,
  input  logic                frame_ready,
  output logic [PAY_BITS-1:0] frame_data,
  output logic                overrun,
  output logic                bit_error
);

  localparam int MAX_BITS = (PAY_BITS > HDR_BITS) ? PAY_BITS : HDR_BITS;
  localparam int LEN_W    = $clog2(MAX_BITS + 1);

  logic             trig_s;
  logic             rise;
  logic             fall;
  logic [CNT_W-1:0] width;

  pulse_width_meter #(
    .CNT_W(CNT_W)
  ) u_meter (
    .clock          (clock),
    .reset          (reset),
    .trigger_signal (trigger_signal),
    .trig_s         (trig_s),
    .rise           (rise),
    .fall           (fall),
    .width          (width)
  );

  pwd_state_t          state, state_nxt;
  logic [LEN_W-1:0]    len, len_nxt;
  logic [PAY_BITS-2:0] bit_buf;
  logic [PAY_BITS-1:0] shifted;
  logic [CNT_W-1:0]    gap_cnt;
  logic                shift_en;
  logic                load_frame;
  logic                valid_nxt;
  logic                err_nxt;
  logic                ovr_nxt;

  logic width_sat;
  logic is_bit0;
  logic is_bit1;
  logic bit_ok;
  logic timeout;
  logic hdr_match;

  assign width_sat = &width;
  assign is_bit0   = (width >= CNT_W'(LB0)) && (width <= CNT_W'(UB0));
  assign is_bit1   = (width >= CNT_W'(LB1)) && (width <= CNT_W'(UB1));
  assign bit_ok    = !width_sat && (is_bit0 || is_bit1);
  assign shifted   = {bit_buf, is_bit1};
  assign hdr_match = (shifted[HDR_BITS-1:0] == HEADER);
  assign timeout   = (gap_cnt > CNT_W'(GAP_MAX));

  always_comb begin
    state_nxt  = state;
    len_nxt    = len;
    shift_en   = 1'b0;
    load_frame = 1'b0;
    valid_nxt  = frame_valid;
    err_nxt    = 1'b0;
    ovr_nxt    = 1'b0;

    case (state)
      ST_IDLE: begin
        if (fall) begin
          if (bit_ok) begin
            shift_en  = 1'b1;
            len_nxt   = LEN_W'(1);
            state_nxt = ST_HDR;
          end else begin
            err_nxt = 1'b1;
          end
        end
      end

      ST_HDR: begin
        if (timeout) begin
          err_nxt   = 1'b1;
          state_nxt = ST_IDLE;
        end else if (fall) begin
          if (!bit_ok) begin
            err_nxt   = 1'b1;
            state_nxt = ST_IDLE;
          end else begin
            shift_en = 1'b1;
            if (len == LEN_W'(HDR_BITS - 1)) begin
              // No sliding search: a wrong header drops everything.
              if (hdr_match) begin
                len_nxt   = '0;
                state_nxt = ST_PAY;
              end else begin
                err_nxt   = 1'b1;
                state_nxt = ST_IDLE;
              end
            end else begin
              len_nxt = len + LEN_W'(1);
            end
          end
        end
      end

      ST_PAY: begin
        if (timeout) begin
          err_nxt   = 1'b1;
          state_nxt = ST_IDLE;
        end else if (fall) begin
          if (!bit_ok) begin
            err_nxt   = 1'b1;
            state_nxt = ST_IDLE;
          end else begin
            shift_en = 1'b1;
            if (len == LEN_W'(PAY_BITS - 1)) begin
              load_frame = 1'b1;
              valid_nxt  = 1'b1;
              state_nxt  = ST_HOLD;
            end else begin
              len_nxt = len + LEN_W'(1);
            end
          end
        end
      end

      ST_HOLD: begin
        // Any pulse finishing here is dropped, even on the accept cycle.
        if (fall) begin
          ovr_nxt = 1'b1;
        end
        if (frame_valid && frame_ready) begin
          valid_nxt = 1'b0;
          state_nxt = ST_IDLE;
        end
      end

      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      len         <= '0;
      bit_buf     <= '0;
      frame_valid <= 1'b0;
      frame_data  <= '0;
      overrun     <= 1'b0;
      bit_error   <= 1'b0;
    end else begin
      state       <= state_nxt;
      len         <= len_nxt;
      frame_valid <= valid_nxt;
      overrun     <= ovr_nxt;
      bit_error   <= err_nxt;
      if (shift_en) begin
        bit_buf <= shifted[PAY_BITS-2:0];
      end
      if (load_frame) begin
        frame_data <= shifted;
      end
    end
  end

  // Free-running low-time counter; only HDR and PAY act on it, and every
  // frame starts from a rise, so it is always fresh when a frame begins.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      gap_cnt <= '0;
    end else if (rise) begin
      gap_cnt <= '0;
    end else if (!trig_s && !(&gap_cnt)) begin
      gap_cnt <= gap_cnt + CNT_W'(1);
    end
  end

endmodule
